temp_conv_pipe: RTL
===================

TEMP_CONV_PIPE -- requirements
Module: temp_conv_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter IN_W, default 8: width of the input temperature (unsigned integer degrees).
REQ-003 Parameter OUT_W, default 8: width of the output temperature (unsigned integer degrees).
REQ-004 Parameter C_MAX, default 100: highest legal Celsius input. Lowest legal Celsius input is 0.
REQ-005 Parameter F_MIN, default 32, and F_MAX, default 212: legal Fahrenheit input range.
REQ-006 Parameter C2F_FILE, default "c2f_table.txt": binary init file for the C->F ROM.
REQ-007 Parameter F2C_FILE, default "f2c_table.txt": binary init file for the F->C ROM.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 in_valid  in  1  input temperature present.
REQ-011 in_ready  out  1  block accepts input this cycle.
REQ-012 in_temp  in  IN_W  input temperature.
REQ-013 unit  in  1  conversion mode: 1 = Celsius->Fahrenheit, 0 = Fahrenheit->Celsius.
REQ-014 out_valid  out  1  result present.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 out_temp  out  OUT_W  converted temperature.
REQ-017 out_unit  out  1  mode that produced this result.
REQ-018 out_err  out  1  input was out of range for its mode.
REQ-019 err_count  out  8  saturating count of out-of-range inputs accepted.

Function
REQ-020 Transfer rule: input accepted when in_valid && in_ready at a rising edge; output consumed when out_valid && out_ready.
REQ-021 stall = out_valid && !out_ready; in_ready = !stall (combinational); while stall is high, every pipeline register holds.
REQ-022 Stage 1 (register on accept): s1_valid, mode, range-error flag, ROM index. Index = in_temp for mode 1 and in_temp - F_MIN for mode 0. When no input is accepted and there is no stall, s1_valid clears.
REQ-023 Stage 2 (output register): registered synchronous ROM read of the selected table at the stage-1 index; loads out_valid, out_temp, out_unit and out_err from stage 1 whenever there is no stall.
REQ-024 Latency: input accepted in cycle n gives out_valid in cycle n+2 when there is no stall. Throughput is one result per cycle.
REQ-025 C->F ROM: depth C_MAX+1; entry c = floor((c*9 + 2)/5) + 32, i.e. c*9/5 rounded half-up, plus 32.
REQ-026 F->C ROM: depth F_MAX-F_MIN+1; entry i = floor((i*5 + 4)/9), i.e. i*5/9 rounded half-up.
REQ-027 Range error: mode 1 with in_temp > C_MAX, or mode 0 with in_temp < F_MIN or in_temp > F_MAX. The result emerges in order with out_err=1 and out_temp=0. The ROM index is forced to 0, so no out-of-bounds read occurs.
REQ-028 err_count increments by 1 on each accepted out-of-range input and saturates at 255 (no wrap).
REQ-029 Results leave in acceptance order; no result is dropped or duplicated under any out_ready pattern.
REQ-030 Inputs in both modes may interleave on consecutive cycles; each result carries its own out_unit.
REQ-031 If out_ready drops while out_valid is high, out_temp, out_unit and out_err hold stable until consumed.

Reset
REQ-032 When reset is high at a rising edge: s1_valid=0, out_valid=0, out_temp=0, out_unit=0, out_err=0, err_count=0. in_ready=1 in the following cycle.
REQ-033 Reset takes priority over all transfers. In-flight items are discarded and never appear at the output. ROM contents are unaffected.

Verification
REQ-034 Basic C->F: unit=1 with inputs 0, 1, 25, 37, 100, out_ready=1 -> outputs 32, 34, 77, 99, 212 in cycles n+2..n+6, out_err=0.
REQ-035 Basic F->C: unit=0 with inputs 32, 33, 98, 212 -> outputs 0, 1, 37, 100, out_unit=0.
REQ-036 Range errors: unit=1 in_temp=101, then unit=0 in_temp=31, then unit=0 in_temp=213 -> three results with out_err=1 and out_temp=0; err_count=3. Inputs accepted after 255 errors leave err_count at 255.
REQ-037 Backpressure: stream 6 mixed-mode inputs while out_ready is low for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 6 results delivered in order with correct values.
REQ-038 Reset mid-operation: accept 2 inputs, assert reset the next cycle -> out_valid never asserts for them; out_valid=0 and err_count=0 after reset; new input 25 (unit=1) -> 77 two cycles later.

Source files
------------

// File: rtl/temp_conv_pipe.sv
// temp_conv_pipe
//   Two-stage Celsius/Fahrenheit converter with valid/ready handshakes on
//   both sides. Stage 1 registers the mode, the range-error flag and the
//   ROM index; stage 2 is the registered ROM read that forms the output.
//   Out-of-range inputs flow through in order with out_err=1 and
//   out_temp=0, and are tallied in a saturating error counter.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      input temperature present
//   in_ready   out  1      block accepts input this cycle
//   in_temp    in   IN_W   input temperature (unsigned degrees)
//   unit       in   1      1 = Celsius->Fahrenheit, 0 = Fahrenheit->Celsius
//   out_valid  out  1      result present
//   out_ready  in   1      consumer accepts result
//   out_temp   out  OUT_W  converted temperature
//   out_unit   out  1      mode that produced this result
//   out_err    out  1      input was out of range for its mode
//   err_count  out  8      saturating count of accepted out-of-range inputs
module temp_conv_pipe #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 8,
    parameter int C_MAX    = 100,
    parameter int F_MIN    = 32,
    parameter int F_MAX    = 212,
    parameter     C2F_FILE = "c2f_table.txt",
    parameter     F2C_FILE = "f2c_table.txt"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_temp,
    input  logic             unit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_temp,
    output logic             out_unit,
    output logic             out_err,
    output logic [7:0]       err_count
);

    localparam int C_DEPTH = C_MAX + 1;
    localparam int F_DEPTH = F_MAX - F_MIN + 1;
    localparam int C_IDX_W = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam int F_IDX_W = (F_DEPTH > 1) ? $clog2(F_DEPTH) : 1;
    localparam int IDX_W   = (C_IDX_W > F_IDX_W) ? C_IDX_W : F_IDX_W;

    localparam logic [IN_W-1:0] C_MAX_V = IN_W'(C_MAX);
    localparam logic [IN_W-1:0] F_MIN_V = IN_W'(F_MIN);
    localparam logic [IN_W-1:0] F_MAX_V = IN_W'(F_MAX);

    // The ROM images are built at elaboration from the conversion formulas;
    // the file names identify the matching binary images used by memory
    // preload flows, so an empty name is rejected outright.
    if (C2F_FILE == "" || F2C_FILE == "") begin : g_bad_rom_name
        $error("temp_conv_pipe: ROM image file names must be non-empty");
    end

    // c*9/5 rounded half-up, plus 32
    function automatic logic [OUT_W-1:0] c2f_entry(input int c);
        return OUT_W'((c * 9 + 2) / 5 + 32);
    endfunction

    // i*5/9 rounded half-up, where i = F - F_MIN
    function automatic logic [OUT_W-1:0] f2c_entry(input int i);
        return OUT_W'((i * 5 + 4) / 9);
    endfunction

    logic [OUT_W-1:0] c2f_rom [C_DEPTH];
    logic [OUT_W-1:0] f2c_rom [F_DEPTH];

    for (genvar gi = 0; gi < C_DEPTH; gi++) begin : g_c2f
        assign c2f_rom[gi] = c2f_entry(gi);
    end

    for (genvar gj = 0; gj < F_DEPTH; gj++) begin : g_f2c
        assign f2c_rom[gj] = f2c_entry(gj);
    end

    // Handshake
    logic stall;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // Input range check and ROM index
    logic             in_err;
    logic [IDX_W-1:0] in_idx;

    always_comb begin
        in_err = '0;
        in_idx = '0;
        if (unit) begin
            in_err = (in_temp > C_MAX_V);
        end else begin
            in_err = (in_temp < F_MIN_V) || (in_temp > F_MAX_V);
        end
        // Out-of-range inputs read entry 0 so the ROM is never indexed
        // past its end; the result is zeroed in stage 2 anyway.
        if (!in_err) begin
            if (unit) begin
                in_idx = IDX_W'(in_temp);
            end else begin
                in_idx = IDX_W'(in_temp - F_MIN_V);
            end
        end
    end

    // Stage 1
    logic             s1_valid;
    logic             s1_mode;
    logic             s1_err;
    logic [IDX_W-1:0] s1_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_err   <= 1'b0;
            s1_idx   <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_mode <= unit;
                s1_err  <= in_err;
                s1_idx  <= in_idx;
            end
        end
    end

    // Stage 2: registered ROM read forms the output register
    logic [OUT_W-1:0] rom_word;

    always_comb begin
        rom_word = '0;
        if (s1_mode) begin
            rom_word = c2f_rom[s1_idx[C_IDX_W-1:0]];
        end else begin
            rom_word = f2c_rom[s1_idx[F_IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_temp  <= '0;
            out_unit  <= 1'b0;
            out_err   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            out_temp  <= s1_err ? '0 : rom_word;
            out_unit  <= s1_mode;
            out_err   <= s1_err;
        end
    end

    // Error tally, counted at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (accept && in_err && (err_count != '1)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule
